// File: rtl/line_fetch_pkg.sv
// Shared definitions for the line fetcher: default geometry, FSM state
// encoding and the RGB565 -> RGB888 expansion helper.
// The PATTERN state exists only when TEST_PATTERN_EN is defined.
package line_fetch_pkg;

   localparam int H_RES_DEF        = 800;
   localparam int ADDR_W_DEF       = 22;
   localparam int BURST_LEN_DEF    = 16;
   localparam int STRIDE_BYTES_DEF = 1600;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_DATA    = 3'd2,
      ST_DONE    = 3'd3
`ifdef TEST_PATTERN_EN
      ,
      ST_PATTERN = 3'd4
`endif
   } state_e;

   // Replicate the top bits of each channel into the new low bits so that
   // full-scale 5/6-bit values map to full-scale 8-bit values.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
      return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
   endfunction

endpackage

// File: rtl/line_fetcher_if.sv
// Fetcher-side bus bundle: PSRAM burst command/read-data channel plus the
// line buffer write port. master = line fetcher, slave = PSRAM ctrl/buffer.
interface line_fetcher_if #(
   parameter int ADDR_W = 22
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic              rd_valid;
   logic [15:0]       rd_data;
   logic [9:0]        wr_addr;
   logic [23:0]       wr_data;
   logic              wr_en;

   modport master (
      output cmd_valid, cmd_addr, wr_addr, wr_data, wr_en,
      input  cmd_ready, rd_valid, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_addr, wr_addr, wr_data, wr_en,
      output cmd_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/rgb565_expand.sv
// One-cycle registered write stage: owns the line buffer write port and
// expands RGB565 to RGB888, or passes a ready-made RGB888 word through.
module rgb565_expand
   import line_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid_i,
   input  logic [9:0]  in_addr_i,
   input  logic [15:0] in_rgb565_i,
   input  logic        pass_i,
   input  logic [23:0] pass_rgb888_i,
   output logic        wr_en_o,
   output logic [9:0]  wr_addr_o,
   output logic [23:0] wr_data_o
);

   logic        wr_en_q;
   logic [9:0]  wr_addr_q;
   logic [23:0] wr_data_q;
   logic [23:0] wr_data_d;

   // Select the pixel value to be written: pass-through or expanded word.
   always_comb begin
      wr_data_d = 24'h000000;
      if (pass_i) begin
         wr_data_d = pass_rgb888_i;
      end else begin
         wr_data_d = rgb565_to_888(in_rgb565_i);
      end
   end

   // Register the write; strobe only in the cycle after a valid input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= 10'd0;
         wr_data_q <= 24'h000000;
      end else if (in_valid_i) begin
         wr_en_q   <= 1'b1;
         wr_addr_q <= in_addr_i;
         wr_data_q <= wr_data_d;
      end else begin
         wr_en_q   <= 1'b0;
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;

endmodule

// File: rtl/line_fetcher.sv
// Line fetcher: on a line request, computes the line's PSRAM address,
// issues fixed-length burst reads and writes one full RGB888 line into the
// line buffer. Optional macro TEST_PATTERN_EN adds a generated test pattern.
module line_fetcher
   import line_fetch_pkg::*;
#(
   parameter int H_RES        = H_RES_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int BURST_LEN    = BURST_LEN_DEF,
   parameter int STRIDE_BYTES = STRIDE_BYTES_DEF
) (
   input  logic              clk_psram,
   input  logic              rst,
   input  logic              line_req,
   input  logic [9:0]        line_idx,
   input  logic [ADDR_W-1:0] frame_base,
   input  logic              pattern_en,
   output logic              busy,
   output logic              line_done,
   output logic              overrun,
   line_fetcher_if.master    bus
);

   localparam int                BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [9:0]        LAST_PIX    = 10'(H_RES - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(2 * BURST_LEN);

   state_e            state_q;
   logic [ADDR_W-1:0] line_addr_q;
   logic [ADDR_W-1:0] cmd_addr_q;
   logic [9:0]        pix_cnt_q;
   logic [BEAT_W-1:0] beat_cnt_q;
   logic              busy_q;
   logic              line_done_q;
   logic              overrun_q;
   logic              cmd_valid_q;
   logic              last_q;       // final write issued, waiting for it to land

   logic [31:0]       line_off_d;
   logic [ADDR_W-1:0] line_addr_d;
   logic [ADDR_W-1:0] next_burst_d;
   logic              more_pix_d;
   logic              beat_d;
   logic              pat_sel_d;
   logic [23:0]       pat_data_d;
   logic              wr_valid_d;

`ifdef TEST_PATTERN_EN
   logic [7:0]        pat_line_q;
`else
   logic              unused_pattern_en;
   assign unused_pattern_en = pattern_en;
`endif

   // Address arithmetic, burst continuation test and write-stage request.
   always_comb begin
      line_off_d   = 32'(line_idx) * 32'(STRIDE_BYTES);
      line_addr_d  = frame_base + line_off_d[ADDR_W-1:0];
      next_burst_d = line_addr_q + BURST_BYTES;
      more_pix_d   = ({1'b0, pix_cnt_q} + 11'd1) < 11'(H_RES);
      beat_d       = (state_q == ST_DATA) && !last_q && bus.rd_valid;
`ifdef TEST_PATTERN_EN
      if (state_q == ST_PATTERN && !last_q) begin
         pat_sel_d = 1'b1;
      end else begin
         pat_sel_d = 1'b0;
      end
      pat_data_d = {pat_line_q, pix_cnt_q[7:0], pat_line_q ^ pix_cnt_q[7:0]};
`else
      pat_sel_d  = 1'b0;
      pat_data_d = 24'h000000;
`endif
      wr_valid_d   = beat_d | pat_sel_d;
   end

   // Main control FSM with registered handshake and status outputs.
   always_ff @(posedge clk_psram or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         line_addr_q <= '0;
         cmd_addr_q  <= '0;
         pix_cnt_q   <= 10'd0;
         beat_cnt_q  <= '0;
         busy_q      <= 1'b0;
         line_done_q <= 1'b0;
         overrun_q   <= 1'b0;
         cmd_valid_q <= 1'b0;
         last_q      <= 1'b0;
`ifdef TEST_PATTERN_EN
         pat_line_q  <= 8'd0;
`endif
      end else begin
         line_done_q <= 1'b0;
         // Any request outside IDLE (including the DONE cycle) is an overrun.
         if (line_req && state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (line_req) begin
                  busy_q      <= 1'b1;
                  pix_cnt_q   <= 10'd0;
                  last_q      <= 1'b0;
                  line_addr_q <= line_addr_d;
`ifdef TEST_PATTERN_EN
                  pat_line_q  <= line_idx[7:0];
                  if (pattern_en) begin
                     state_q <= ST_PATTERN;
                  end else
`endif
                  begin
                     state_q     <= ST_CMD;
                     cmd_valid_q <= 1'b1;
                     cmd_addr_q  <= line_addr_d;
                  end
               end
            end
            ST_CMD: begin
               if (cmd_valid_q && bus.cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  beat_cnt_q  <= '0;
                  state_q     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (last_q) begin
                  last_q      <= 1'b0;
                  busy_q      <= 1'b0;
                  line_done_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else if (bus.rd_valid) begin
                  beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                  if (pix_cnt_q != LAST_PIX) begin
                     pix_cnt_q <= pix_cnt_q + 10'd1;
                  end
                  if (beat_cnt_q == LAST_BEAT) begin
                     if (more_pix_d) begin
                        line_addr_q <= next_burst_d;
                        cmd_addr_q  <= next_burst_d;
                        cmd_valid_q <= 1'b1;
                        state_q     <= ST_CMD;
                     end else begin
                        last_q <= 1'b1;
                     end
                  end
               end
            end
`ifdef TEST_PATTERN_EN
            ST_PATTERN: begin
               if (last_q) begin
                  last_q      <= 1'b0;
                  busy_q      <= 1'b0;
                  line_done_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else if (pix_cnt_q == LAST_PIX) begin
                  last_q <= 1'b1;
               end else begin
                  pix_cnt_q <= pix_cnt_q + 10'd1;
               end
            end
`endif
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   rgb565_expand u_expand (
      .clk           (clk_psram),
      .rst           (rst),
      .in_valid_i    (wr_valid_d),
      .in_addr_i     (pix_cnt_q),
      .in_rgb565_i   (bus.rd_data),
      .pass_i        (pat_sel_d),
      .pass_rgb888_i (pat_data_d),
      .wr_en_o       (bus.wr_en),
      .wr_addr_o     (bus.wr_addr),
      .wr_data_o     (bus.wr_data)
   );

   assign busy          = busy_q;
   assign line_done     = line_done_q;
   assign overrun       = overrun_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_addr  = cmd_addr_q;

endmodule

// File: tb/tb_line_fetcher.sv
// Scoreboard bench for line_fetcher: acts as PSRAM controller, queues the
// expected line buffer writes when read beats are driven, and compares them
// against the write port as it is observed.
module tb_line_fetcher;

   localparam int H      = 800;
   localparam int BL     = 16;
   localparam int NB     = H / BL;
   localparam int STRIDE = 1600;

   typedef struct {
      logic [9:0]  a;
      logic [23:0] d;
      int          c;
   } exp_t;

   logic        clk_psram = 1'b0;
   logic        rst;
   logic        line_req;
   logic [9:0]  line_idx;
   logic [21:0] frame_base;
   logic        pattern_en;
   logic        busy;
   logic        line_done;
   logic        overrun;

   line_fetcher_if #(.ADDR_W(22)) bus ();

   line_fetcher dut (
      .clk_psram  (clk_psram),
      .rst        (rst),
      .line_req   (line_req),
      .line_idx   (line_idx),
      .frame_base (frame_base),
      .pattern_en (pattern_en),
      .busy       (busy),
      .line_done  (line_done),
      .overrun    (overrun),
      .bus        (bus)
   );

   always #5 clk_psram = ~clk_psram;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          line_cyc = 0;
   int          dup_at = 0;
   int          wr_count = 0;
   int          done_cnt = 0;
   int          cmd_hi_cnt = 0;
   int          last_wr_cyc = 0;
   logic [9:0]  last_wr_addr = 10'd0;
   exp_t        exp_q[$];
   logic [15:0] tab_rd  [0:3];
   logic [23:0] tab_exp [0:3];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference expansion written as shift/or arithmetic per channel.
   function automatic logic [23:0] m565(input logic [15:0] w);
      logic [7:0] r, g, b;
      r = ({3'b000, w[15:11]} << 3) | ({3'b000, w[15:11]} >> 2);
      g = ({2'b00, w[10:5]} << 2)   | ({2'b00, w[10:5]} >> 4);
      b = ({3'b000, w[4:0]} << 3)   | ({3'b000, w[4:0]} >> 2);
      return {r, g, b};
   endfunction

   // Observe DUT outputs mid-cycle and score them.
   task automatic sample();
      exp_t e;
      if (rst) begin
         exp_q.delete();
      end else if (bus.wr_en) begin
         if (exp_q.size() == 0) begin
            check_eq("wr_spurious", 32'(bus.wr_en), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("wr_addr", 32'(bus.wr_addr), 32'(e.a));
            check_eq("wr_data", 32'(bus.wr_data), 32'(e.d));
            check_eq("wr_cycle", 32'(cyc), 32'(e.c));
         end
         wr_count++;
         last_wr_cyc  = cyc;
         last_wr_addr = bus.wr_addr;
      end
      if (bus.cmd_valid) cmd_hi_cnt++;
      if (line_done) begin
         done_cnt++;
         check_eq("done_gap", 32'(cyc - last_wr_cyc), 32'd1);
         check_eq("done_addr", 32'(last_wr_addr), 32'(H - 1));
         check_eq("done_busy", 32'(busy), 32'd0);
      end
   endtask

   // Advance one clock: sample at negedge, drive 1 time unit after posedge.
   task automatic tick();
      @(negedge clk_psram);
      sample();
      @(posedge clk_psram);
      cyc++;
      #1;
      line_cyc++;
      line_req = (dup_at > 0 && line_cyc == dup_at);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(line_done), 32'd0);
      check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
      check_eq({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
      check_eq({tag, "_cmd_addr"}, 32'(bus.cmd_addr), 32'd0);
      check_eq({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
      check_eq({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
      check_eq({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
   endtask

   task automatic run_line(input logic [9:0] idx, input logic [21:0] base, input int stall,
                           input bit gap, input int abort_burst, input int dup, input bit use_tab);
      int          w0, d0, n, pix;
      logic [21:0] ea;
      logic [15:0] rd;
      logic [23:0] ed;
      exp_t        e;
      w0 = wr_count;
      d0 = done_cnt;
      pix = 0;
      bus.cmd_ready = (stall == 0);
      line_idx   = idx;
      frame_base = base;
      pattern_en = 1'b0;
      line_cyc   = 0;
      dup_at     = dup;
      line_req   = 1'b1;
      tick();
      check_eq("req_latency", 32'(bus.cmd_valid), 32'd1);
      check_eq("busy_set", 32'(busy), 32'd1);
      for (int bi = 0; bi < NB; bi++) begin
         n = 0;
         while (!bus.cmd_valid && n < 40) begin
            tick();
            n++;
         end
         if (!bus.cmd_valid) begin
            check_eq("cmd_timeout", 32'(bus.cmd_valid), 32'd1);
            dup_at = 0;
            return;
         end
         ea = base + 22'(32'(idx) * 32'(STRIDE)) + 22'(bi * 2 * BL);
         check_eq("cmd_addr", 32'(bus.cmd_addr), 32'(ea));
         for (int s = 0; s < stall; s++) begin
            bus.cmd_ready = 1'b0;
            bus.rd_valid  = 1'b1;
            bus.rd_data   = 16'hDEAD;
            tick();
            check_eq("cmd_hold_valid", 32'(bus.cmd_valid), 32'd1);
            check_eq("cmd_hold_addr", 32'(bus.cmd_addr), 32'(ea));
         end
         bus.rd_valid  = 1'b0;
         bus.cmd_ready = 1'b1;
         tick();
         bus.cmd_ready = (stall == 0);
         check_eq("cmd_drop", 32'(bus.cmd_valid), 32'd0);
         for (int b = 0; b < BL; b++) begin
            if (gap && b > 0) begin
               bus.rd_valid = 1'b0;
               bus.rd_data  = 16'($urandom);
               tick();
            end
            if (bi == abort_burst && b == 5) begin
               bus.rd_valid = 1'b0;
               rst = 1'b1;
               tick();
               check_all_zero("abort");
               d0 = done_cnt;
               repeat (3) tick();
               rst = 1'b0;
               tick();
               check_eq("abort_no_done", 32'(done_cnt), 32'(d0));
               dup_at = 0;
               return;
            end
            rd = (use_tab && pix < 4) ? tab_rd[pix] : 16'($urandom);
            ed = (use_tab && pix < 4) ? tab_exp[pix] : m565(rd);
            bus.rd_valid = 1'b1;
            bus.rd_data  = rd;
            e.a = 10'(pix);
            e.d = ed;
            e.c = cyc + 1;
            exp_q.push_back(e);
            tick();
            pix++;
         end
         bus.rd_valid = 1'b0;
      end
      n = 0;
      while (done_cnt == d0 && n < 20) begin
         tick();
         n++;
      end
      check_eq("line_done_count", 32'(done_cnt - d0), 32'd1);
      check_eq("write_count", 32'(wr_count - w0), 32'(H));
      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      check_eq("busy_clear", 32'(busy), 32'd0);
      dup_at = 0;
   endtask

`ifdef TEST_PATTERN_EN
   task automatic run_pattern(input logic [9:0] idx);
      int   w0, d0, c0, n;
      exp_t e;
      w0 = wr_count;
      d0 = done_cnt;
      c0 = cmd_hi_cnt;
      bus.cmd_ready = 1'b1;
      line_idx   = idx;
      frame_base = 22'h000000;
      pattern_en = 1'b1;
      line_cyc   = 0;
      dup_at     = 0;
      for (int p = 0; p < H; p++) begin
         e.a = 10'(p);
         e.d = (idx == 10'd3 && p == 5) ? 24'h030506
                                        : {idx[7:0], 8'(p), idx[7:0] ^ 8'(p)};
         e.c = cyc + 2 + p;
         exp_q.push_back(e);
      end
      line_req = 1'b1;
      tick();
      pattern_en = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < H + 50) begin
         tick();
         n++;
      end
      check_eq("pat_done_count", 32'(done_cnt - d0), 32'd1);
      check_eq("pat_write_count", 32'(wr_count - w0), 32'(H));
      check_eq("pat_no_cmd", 32'(cmd_hi_cnt - c0), 32'd0);
      check_eq("pat_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tab_rd[0] = 16'hF800;  tab_exp[0] = 24'hFF0000;
      tab_rd[1] = 16'h07E0;  tab_exp[1] = 24'h00FF00;
      tab_rd[2] = 16'h001F;  tab_exp[2] = 24'h0000FF;
      tab_rd[3] = 16'h0000;  tab_exp[3] = 24'h000000;
      rst           = 1'b1;
      line_req      = 1'b0;
      pattern_en    = 1'b0;
      line_idx      = 10'd0;
      frame_base    = 22'h000000;
      bus.cmd_ready = 1'b0;
      bus.rd_valid  = 1'b0;
      bus.rd_data   = 16'h0000;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      // rd_valid while idle must not write
      bus.rd_valid = 1'b1;
      bus.rd_data  = 16'hFFFF;
      repeat (3) tick();
      bus.rd_valid = 1'b0;
      tick();

      // line 2 at 0x1000: first burst at 0x1C80, colour table first
      run_line(10'd2, 22'h001000, 0, 1'b0, -1, 0, 1'b1);
      // wrapping address, controller stalls and gapped read data
      run_line(10'd5, 22'h3FFF00, 7, 1'b1, -1, 0, 1'b0);
      check_eq("overrun_before", 32'(overrun), 32'd0);
      // duplicate request 10 cycles in
      run_line(10'd7, 22'h020000, 0, 1'b0, -1, 10, 1'b0);
      check_eq("overrun_set", 32'(overrun), 32'd1);
      run_line(10'd8, 22'h020000, 0, 1'b0, -1, 0, 1'b0);
      check_eq("overrun_sticky", 32'(overrun), 32'd1);
      // reset at beat 5 of the fourth burst, then a clean restart from pixel 0
      run_line(10'd9, 22'h000400, 0, 1'b0, 3, 0, 1'b0);
      run_line(10'd1, 22'h000000, 0, 1'b0, -1, 0, 1'b1);
      check_eq("overrun_after_rst", 32'(overrun), 32'd0);
`ifdef TEST_PATTERN_EN
      run_pattern(10'd3);
`endif
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
